dp_frame_sched: RTL and testbench
=================================

// Module: dp_frame_sched
// PURPOSE
//  Frame/line scheduler for the DisplayPort stuffing datapath, in the dpclk (link-symbol) domain.
//  Generates the dphstart/dpvstart pulses that pace the stuffer.
//  Double-buffers the attribute bundle so stuffer attributes change only on a frame boundary.
//  Sits between the config register file (attr_in/attr_upd) and the stuffer (attr_out/pulses).
// PARAMETERS
//  MINHPER  64  minimum legal line period in dpclk cycles (covers VBLANK SDP + VBID + EOL)
//  AW       `ATTRMAX+1  attribute bundle width (vtot = bits [47:32])
// PORTS
//  dpclk     in   1   link symbol clock
//  reset     in   1   synchronous, active-high
//  enable    in   1   level; 1 = run frames, 0 = stop at the next frame end
//  hper      in   16  line period in dpclk cycles; sampled only at frame start
//  attr_in   in   AW  new attribute bundle from config
//  attr_upd  in   1   1-cycle pulse: capture attr_in as pending
//  attr_out  out  AW  active attribute bundle to stuffer
//  upd_ack   out  1   1-cycle pulse: pending bundle became active
//  dphstart  out  1   1-cycle pulse at start of every line
//  dpvstart  out  1   1-cycle pulse at start of line 0 (coincident with dphstart)
//  line      out  16  current line index 0..vtot-1
//  frame_cnt out  8   completed-frame counter, wraps 255->0
//  running   out  1   1 while in RUN
//  cfg_err   out  1   sticky: start refused (hper<MINHPER or vtot==0); cleared by reset
// BEHAVIOUR
//  Reset: all outputs 0, attr_out=0, pending empty, state OFF, counters 0.
//  Registers: pend_attr, pend_vld, hper_q (hper latched at frame start), hctr, vctr (16 b each).
//  attr_upd: pend_attr<=attr_in, pend_vld<=1; repeated upd before a swap overwrites, one ack.
//  Swap (pend_vld && swap point): attr_out<=pend_attr, pend_vld<=0, upd_ack=1 next cycle.
//  Swap point: any cycle in OFF; in RUN, the last cycle of a frame (hctr==hper_q-1, vctr==vtot-1).
//  attr_upd in the same cycle as a swap: swap uses the old pend_attr; the new value stays pending.
//  State OFF: pulses 0, running=0, hctr=vctr=0.
//   Start when enable=1 and no swap this cycle; checks use the current attr_out.
//   If hper>=MINHPER and vtot!=0: go to RUN, hper_q<=hper, hctr=vctr=0.
//   Else: stay OFF, cfg_err<=1.
//  State RUN: running=1.
//   Pulses: dphstart=1 when hctr==0; dpvstart=1 when hctr==0 && vctr==0 (registered, no comb path).
//   Counters: hctr increments and wraps at hper_q-1; on wrap vctr increments, wrapping at vtot-1.
//   line=vctr.
//   Frame end (last cycle of frame): frame_cnt+=1; swap if pending; hper_q<=hper.
//    If enable=0 -> OFF.
//    Else if hper<MINHPER -> cfg_err<=1, OFF.
//    Else continue at hctr=vctr=0 with the new attr.
//  vtot is read from attr_out, so a swap changes frame height from the next frame on.
//  enable deassert mid-frame: the frame completes with all pulses; no partial frame.
//  reset mid-frame: immediate return to reset values; no further pulses.
//  First dphstart/dpvstart: exactly 1 cycle after the OFF->RUN decision cycle.
//  Pulse period: exactly hper_q cycles.
// TESTING
//  1 attr_upd with vtot=4, then enable=1, hper=100
//    -> upd_ack 1 cycle later; dpvstart every 400 cycles;
//       dphstart at hctr=0 of lines 0..3; line sequence 0,1,2,3,0.
//  2 During RUN, attr_upd vtot=6 at mid-frame
//    -> no ack until the frame's last cycle; next frame has 6 lines; frame_cnt +1 per frame.
//  3 enable=1 with hper=40 (<64)
//    -> cfg_err=1, running=0, no pulses.
//    Then reset, hper=64 -> starts; pulse spacing is 64.
//  4 enable dropped at line 1 of 4
//    -> lines 2,3 still pulse; running falls after the last cycle of line 3; no further dpvstart.
//  5 attr_upd on the exact swap cycle
//    -> attr_out gets the previous pending; the new value is applied at the following frame end.
//  6 reset asserted at hctr=10, vctr=2
//    -> all outputs 0 next cycle; pulses stay 0 until re-enabled.

Source files
------------

// File: rtl/dp_frame_sched.sv
// dp_frame_sched: line/frame pulse generator for the DisplayPort stuffer (dpclk domain).
// Counts hper_q cycles per line and vtot lines per frame, emitting dphstart/dpvstart,
// and double-buffers the attribute bundle so the stuffer only sees changes at frame ends.
module dp_frame_sched #(
  // Shortest legal line period; must leave room for VBLANK SDP, VBID and EOL.
  parameter int unsigned MINHPER = 64,
  // Attribute bundle width; must be at least 48 because vtot lives in bits [47:32].
  parameter int unsigned AW      = 64
) (
  input  logic          dpclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [15:0]   hper,
  input  logic [AW-1:0] attr_in,
  input  logic          attr_upd,
  output logic [AW-1:0] attr_out,
  output logic          upd_ack,
  output logic          dphstart,
  output logic          dpvstart,
  output logic [15:0]   line,
  output logic [7:0]    frame_cnt,
  output logic          running,
  output logic          cfg_err
);

  localparam logic [15:0] MinHper = 16'(MINHPER);

  typedef enum logic [0:0] {StOff, StRun} state_e;

  state_e        st_q, st_d;
  logic [15:0]   hctr_q, hctr_d;
  logic [15:0]   vctr_q, vctr_d;
  logic [15:0]   hper_q, hper_d;
  logic [AW-1:0] attr_q, attr_d;
  logic [AW-1:0] pend_attr_q, pend_attr_d;
  logic          pend_vld_q, pend_vld_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          run_q, run_d;

  logic [15:0]   vtot;
  logic          h_last;
  logic          f_last;
  logic          hper_ok;
  logic          swap;

  // Frame geometry decode against the active bundle and the latched line period.
  always_comb begin
    vtot    = attr_q[47:32];
    h_last  = (hctr_q == hper_q - 16'd1);
    f_last  = (st_q == StRun) && h_last && (vctr_q == vtot - 16'd1);
    hper_ok = (hper >= MinHper);
    // Idle time is always a safe point to swap; while running only the frame's last cycle is.
    swap    = pend_vld_q && ((st_q == StOff) || f_last);
  end

  // Next-state: attribute buffer, run/stop control, counters and registered pulse outputs.
  always_comb begin
    st_d        = st_q;
    hctr_d      = hctr_q;
    vctr_d      = vctr_q;
    hper_d      = hper_q;
    attr_d      = attr_q;
    pend_attr_d = pend_attr_q;
    pend_vld_d  = pend_vld_q;
    fcnt_d      = fcnt_q;
    err_d       = err_q;

    // Swap consumes the old pending bundle; an update in the same cycle re-arms pending.
    if (swap) begin
      attr_d     = pend_attr_q;
      pend_vld_d = 1'b0;
    end
    if (attr_upd) begin
      pend_attr_d = attr_in;
      pend_vld_d  = 1'b1;
    end

    unique case (st_q)
      StOff: begin
        hctr_d = 16'd0;
        vctr_d = 16'd0;
        // Start is deferred while a swap is in flight so the checks see the settled bundle.
        if (enable && !swap) begin
          if (hper_ok && (vtot != 16'd0)) begin
            st_d   = StRun;
            hper_d = hper;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (f_last) begin
          fcnt_d = fcnt_q + 8'd1;
          hper_d = hper;
          hctr_d = 16'd0;
          vctr_d = 16'd0;
          if (!enable) begin
            st_d = StOff;
          end else if (!hper_ok) begin
            err_d = 1'b1;
            st_d  = StOff;
          end
        end else if (h_last) begin
          hctr_d = 16'd0;
          vctr_d = vctr_q + 16'd1;
        end else begin
          hctr_d = hctr_q + 16'd1;
        end
      end
      default: begin
        st_d = StOff;
      end
    endcase

    // Pulses are decoded from next-state so they land in the cycle the counters read zero.
    run_d = (st_d == StRun);
    hs_d  = run_d && (hctr_d == 16'd0);
    vs_d  = hs_d && (vctr_d == 16'd0);
    ack_d = swap;
  end

  // State and output registers; synchronous active-high reset.
  always_ff @(posedge dpclk) begin
    if (reset) begin
      st_q        <= StOff;
      hctr_q      <= 16'd0;
      vctr_q      <= 16'd0;
      hper_q      <= 16'd0;
      attr_q      <= '0;
      pend_attr_q <= '0;
      pend_vld_q  <= 1'b0;
      fcnt_q      <= 8'd0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      hctr_q      <= hctr_d;
      vctr_q      <= vctr_d;
      hper_q      <= hper_d;
      attr_q      <= attr_d;
      pend_attr_q <= pend_attr_d;
      pend_vld_q  <= pend_vld_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      run_q       <= run_d;
    end
  end

  assign attr_out  = attr_q;
  assign upd_ack   = ack_q;
  assign dphstart  = hs_q;
  assign dpvstart  = vs_q;
  assign line      = vctr_q;
  assign frame_cnt = fcnt_q;
  assign running   = run_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_dp_frame_sched.sv
// tb_dp_frame_sched: randomized scoreboard bench for dp_frame_sched.
// The driver plans whole frames arithmetically (pulse k of a frame started at edge S lands
// at S + k*hper) and queues expected pulses/acks; the monitor pops them as the DUT emits.
module tb_dp_frame_sched;
  localparam int MINHPER = 64;
  localparam int AW      = 64;

  logic          dpclk    = 1'b0;
  logic          reset    = 1'b1;
  logic          enable   = 1'b0;
  logic [15:0]   hper     = 16'd0;
  logic [AW-1:0] attr_in  = '0;
  logic          attr_upd = 1'b0;
  logic [AW-1:0] attr_out;
  logic          upd_ack;
  logic          dphstart;
  logic          dpvstart;
  logic [15:0]   line;
  logic [7:0]    frame_cnt;
  logic          running;
  logic          cfg_err;

  dp_frame_sched #(
    .MINHPER(MINHPER),
    .AW     (AW)
  ) dut (
    .dpclk    (dpclk),
    .reset    (reset),
    .enable   (enable),
    .hper     (hper),
    .attr_in  (attr_in),
    .attr_upd (attr_upd),
    .attr_out (attr_out),
    .upd_ack  (upd_ack),
    .dphstart (dphstart),
    .dpvstart (dpvstart),
    .line     (line),
    .frame_cnt(frame_cnt),
    .running  (running),
    .cfg_err  (cfg_err)
  );

  always #5 dpclk = ~dpclk;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge dpclk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    int            ln;
    bit            vs;
    int            fc;
    logic [AW-1:0] attr;
  } pulse_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] attr;
  } ack_t;

  pulse_t pulse_q[$];
  ack_t   ack_q[$];

  // Reference model state (frame level).
  logic [AW-1:0] m_attr = '0;
  logic [AW-1:0] m_pend = '0;
  bit            m_pvld = 1'b0;
  int            m_fcnt = 0;
  bit            m_err  = 1'b0;

  int checks  = 0;
  int errors  = 0;
  bit mon_on  = 1'b0;
  int req_id  = 0;
  int done_id = 0;

  task automatic check(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_attr(int vt);
    logic [AW-1:0] a;
    a        = {$urandom(), $urandom()};
    a[47:32] = vt[15:0];
    return a;
  endfunction

  // Monitor: consumes expected pulses/acks and performs requested idle checks.
  pulse_t mp;
  ack_t   ma;
  always @(negedge dpclk) begin
    if (mon_on) begin
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        mp = pulse_q.pop_front();
        checks++;
        errors++;
        $display("FAIL pulse_missing: line %0d pulse due at cycle %0d, not observed by cycle %0d",
                 mp.ln, mp.cyc, cyc);
      end
      while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
        ma = ack_q.pop_front();
        checks++;
        errors++;
        $display("FAIL ack_missing: upd_ack due at cycle %0d, not observed by cycle %0d",
                 ma.cyc, cyc);
      end
      if (dphstart || dpvstart) begin
        if (pulse_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: dphstart=%0b dpvstart=%0b, none expected",
                   cyc, dphstart, dpvstart);
        end else begin
          mp = pulse_q.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(mp.cyc));
          check("dphstart", 64'(dphstart), 64'd1);
          check("dpvstart", 64'(dpvstart), 64'(mp.vs));
          check("line", 64'(line), 64'(mp.ln));
          check("frame_cnt", 64'(frame_cnt), 64'(mp.fc));
          check("attr_out_run", attr_out, mp.attr);
          check("running", 64'(running), 64'd1);
        end
      end
      if (upd_ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack at cycle %0d: upd_ack=1, none expected", cyc);
        end else begin
          ma = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(ma.cyc));
          check("ack_attr_out", attr_out, ma.attr);
        end
      end
      if (req_id != done_id) begin
        check("idle_running", 64'(running), 64'd0);
        check("idle_dphstart", 64'(dphstart), 64'd0);
        check("idle_dpvstart", 64'(dpvstart), 64'd0);
        check("idle_line", 64'(line), 64'd0);
        check("idle_attr_out", attr_out, m_attr);
        check("idle_frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
        check("idle_cfg_err", 64'(cfg_err), 64'(m_err));
        check("idle_pulses_left", 64'(pulse_q.size()), 64'd0);
        check("idle_acks_left", 64'(ack_q.size()), 64'd0);
        done_id = req_id;
      end
    end
  end

  task automatic drive(bit en, int hp, bit upd, logic [AW-1:0] a);
    enable   = en;
    hper     = hp[15:0];
    attr_upd = upd;
    attr_in  = a;
    @(posedge dpclk);
    #1;
    attr_upd = 1'b0;
  endtask

  task automatic idle_check();
    req_id++;
    @(negedge dpclk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset    = 1'b1;
    enable   = 1'b0;
    attr_upd = 1'b0;
    repeat (n) @(posedge dpclk);
    #1;
    reset  = 1'b0;
    m_attr = '0;
    m_pvld = 1'b0;
    m_fcnt = 0;
    m_err  = 1'b0;
    pulse_q.delete();
    ack_q.delete();
  endtask

  // One idle-state edge: a pending bundle is applied, otherwise enable attempts a start.
  task automatic off_edge(bit en, int hp, bit upd, logic [AW-1:0] a, output bit started);
    int e;
    e       = cyc + 1;
    started = 1'b0;
    if (m_pvld) begin
      ack_q.push_back(ack_t'{e, m_pend});
      m_attr = m_pend;
      m_pvld = 1'b0;
    end else if (en) begin
      if (hp >= MINHPER && m_attr[47:32] != 16'd0) started = 1'b1;
      else m_err = 1'b1;
    end
    if (upd) begin
      m_pend = a;
      m_pvld = 1'b1;
    end
    drive(en, hp, upd, a);
  endtask

  // Run frames from the current edge. mode for the last frame: 0 enable low at its end,
  // 1 enable low mid-frame, 2 illegal hper at its end, 3 reset mid-frame.
  // force_vt > 0 forces a mid-frame update (that vtot) and an update on frame 0's end edge.
  // ev_at > 0 fixes the in-frame cycle offset of the mode 1/3 event; otherwise it is random.
  task automatic run(int h0, int nfr, int mode, int force_vt, int ev_at);
    int            s, h, v, len, ev_k, e, hp;
    bit            en, upd, last, stop, fmid;
    logic [AW-1:0] a;
    s    = cyc;
    h    = h0;
    stop = 1'b0;
    for (int f = 0; f < nfr && !stop; f++) begin
      v    = int'(m_attr[47:32]);
      len  = v * h;
      last = (f == nfr - 1);
      for (int l = 0; l < v; l++) pulse_q.push_back(pulse_t'{s + l * h, l, l == 0, m_fcnt, m_attr});
      ev_k = (ev_at > 0 && ev_at < len) ? ev_at : int'($urandom_range(1, len - 1));
      en   = 1'b1;
      for (int k = 1; k < len; k++) begin
        if (last && mode == 3 && k == ev_k) begin
          e = cyc + 1;
          while (pulse_q.size() > 0 && pulse_q[pulse_q.size() - 1].cyc >= e) void'(pulse_q.pop_back());
          reset    = 1'b1;
          enable   = 1'b0;
          attr_upd = 1'b0;
          @(posedge dpclk);
          #1;
          reset  = 1'b0;
          m_attr = '0;
          m_pvld = 1'b0;
          m_fcnt = 0;
          m_err  = 1'b0;
          return;
        end
        if (last && mode == 1 && k >= ev_k) en = 1'b0;
        fmid = (force_vt > 0 && f == 0 && k == len / 2);
        upd  = fmid || ($urandom_range(0, 199) == 0);
        a    = mk_attr(fmid ? force_vt : int'($urandom_range(1, 5)));
        if (upd) begin
          m_pend = a;
          m_pvld = 1'b1;
        end
        // hper is garbage mid-frame: only the frame-end sample may matter.
        drive(en, int'($urandom_range(0, 65535)), upd, a);
      end
      e   = cyc + 1;
      upd = (force_vt > 0 && f == 0) || ($urandom_range(0, 2) == 0);
      a   = mk_attr(int'($urandom_range(1, 4)));
      if (last && mode != 2) en = 1'b0;
      hp = (last && mode == 2) ? int'($urandom_range(1, MINHPER - 1)) : int'($urandom_range(64, 80));
      m_fcnt = (m_fcnt + 1) % 256;
      if (m_pvld) begin
        ack_q.push_back(ack_t'{e, m_pend});
        m_attr = m_pend;
        m_pvld = 1'b0;
      end
      if (upd) begin
        m_pend = a;
        m_pvld = 1'b1;
      end
      if (!en) stop = 1'b1;
      else if (hp < MINHPER) begin
        m_err = 1'b1;
        stop  = 1'b1;
      end else begin
        s = e;
        h = hp;
      end
      drive(en, hp, upd, a);
    end
  endtask

  initial begin
    bit st;
    int hp;
    do_reset(3);
    mon_on = 1'b1;
    idle_check();

    // vtot=4, hper=100; mid-frame update to vtot=6 plus an update on the exact swap edge.
    off_edge(1'b0, 100, 1'b1, mk_attr(4), st);
    off_edge(1'b0, 100, 1'b0, '0, st);
    off_edge(1'b1, 100, 1'b0, '0, st);
    if (st) run(100, 3, 0, 6, 0);
    idle_check();

    // Short hper is refused and sticky; reset clears it.
    off_edge(1'b0, 100, 1'b1, mk_attr(3), st);
    off_edge(1'b0, 100, 1'b0, '0, st);
    off_edge(1'b1, 40, 1'b0, '0, st);
    off_edge(1'b0, 40, 1'b0, '0, st);
    idle_check();
    do_reset(2);
    idle_check();
    // vtot==0 straight after reset is refused as well.
    off_edge(1'b1, 100, 1'b0, '0, st);
    idle_check();
    do_reset(1);
    off_edge(1'b0, 64, 1'b1, mk_attr(2), st);
    off_edge(1'b0, 64, 1'b0, '0, st);
    off_edge(1'b1, 64, 1'b0, '0, st);
    if (st) run(64, 2, 0, 0, 0);
    idle_check();

    // enable dropped during line 1 of 4: lines 2 and 3 still pulse.
    off_edge(1'b0, 64, 1'b1, mk_attr(4), st);
    off_edge(1'b0, 64, 1'b0, '0, st);
    off_edge(1'b1, 64, 1'b0, '0, st);
    if (st) run(64, 1, 1, 0, 64 + 11);
    idle_check();

    // Reset while hctr=10, vctr=2.
    off_edge(1'b0, 70, 1'b1, mk_attr(4), st);
    off_edge(1'b0, 70, 1'b0, '0, st);
    off_edge(1'b1, 70, 1'b0, '0, st);
    if (st) run(70, 1, 3, 0, 2 * 70 + 11);
    idle_check();
    repeat (20) drive(1'b0, 100, 1'b0, '0);
    idle_check();

    // Randomized sessions.
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < int'($urandom_range(0, 5)); i++)
        off_edge(1'b0, 100, ($urandom_range(0, 2) == 0), mk_attr(int'($urandom_range(1, 5))), st);
      off_edge(1'b0, 100, 1'b1, mk_attr(int'($urandom_range(1, 5))), st);
      off_edge(1'b0, 100, 1'b0, '0, st);
      hp = int'($urandom_range(56, 80));
      off_edge(1'b1, hp, 1'b0, '0, st);
      if (st) run(hp, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, 0);
      idle_check();
      if (m_err && ($urandom_range(0, 1) == 1)) begin
        do_reset(1);
        idle_check();
      end
    end

    repeat (5) drive(1'b0, 100, 1'b0, '0);
    idle_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
